// File: rtl/inst_fetch_queue.sv
// Purpose : decoupled fetch front end; owns the fetch PC, issues in-order
//           memory requests and queues the returned {pc, inst} pairs for IF_ID.
// Latency : request accepted in cycle N, response in cycle M>=N+1, instValid in M+1
//           (M+0 when FETCH_BYPASS_EN is defined).
// Backpressure: memReqValid drops when all DEPTH entries are allocated or on flush;
//           locker=1 holds the head entry in place.
//
// Ports:
//   clk, resetIn (async, active-low)
//   flush, flushAddr      : branch redirect, highest priority
//   locker                : IF_ID stall, 1 = do not pop
//   memReqValid/Addr/Ready: fetch request channel (valid/ready)
//   memRespValid/Data     : in-order response channel (valid only)
//   instValid/instOut/pcOut: head of the queue towards IF_ID
//
// Optional feature macro: FETCH_BYPASS_EN (response forwarded straight to
// instOut when it fills the head entry).
module inst_fetch_queue #(
  parameter int                 DEPTH    = 4,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              flush,
  input  logic [DATA_W-1:0] flushAddr,
  input  logic              locker,
  output logic              memReqValid,
  output logic [DATA_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRespValid,
  input  logic [DATA_W-1:0] memRespData,
  output logic              instValid,
  output logic [DATA_W-1:0] instOut,
  output logic [DATA_W-1:0] pcOut
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [PTR_W-1:0]  head_ptr, tail_ptr, fill_ptr;
  logic [CNT_W-1:0]  count, outstanding, drop_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [DATA_W-1:0] fetch_pc, last_pc;

  logic req_fire, resp_drop, resp_fill, head_filled, head_bypass, pop;

  assign memReqValid = resetIn && !flush && (count < CNT_W'(DEPTH));
  assign memReqAddr  = fetch_pc;
  assign req_fire    = memReqValid && memReqReady;

  // A response first pays off pending drops; only then does it fill an entry.
  assign resp_drop   = memRespValid && (drop_cnt != '0);
  assign resp_fill   = memRespValid && (drop_cnt == '0) && (outstanding != '0) && !flush;
  assign head_filled = (count != '0) && filled_q[head_ptr];
  assign inflight    = drop_cnt + outstanding;

`ifdef FETCH_BYPASS_EN
  // fill_ptr is the oldest unfilled entry; if it is the head, forward the data.
  assign head_bypass = resp_fill && (fill_ptr == head_ptr);
  always_comb begin
    instOut = NOP;
    if (head_filled)      instOut = inst_q[head_ptr];
    else if (head_bypass) instOut = memRespData;
  end
`else
  assign head_bypass = 1'b0;
  assign instOut     = head_filled ? inst_q[head_ptr] : NOP;
`endif

  assign instValid = head_filled || head_bypass;
  assign pcOut     = instValid ? pc_q[head_ptr] : last_pc;
  assign pop       = instValid && !locker && !flush;

  // Payload storage needs no reset: entries are qualified by count/filled_q.
  always_ff @(posedge clk) begin
    if (req_fire)  pc_q[tail_ptr]   <= fetch_pc;
    if (resp_fill) inst_q[fill_ptr] <= memRespData;
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      fill_ptr    <= '0;
      filled_q    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      last_pc     <= '0;
    end else if (flush) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      fill_ptr    <= '0;
      filled_q    <= '0;
      count       <= '0;
      outstanding <= '0;
      fetch_pc    <= flushAddr;
      // Every request still at the memory becomes a drop. A same-cycle response
      // retires one of them, whichever counter it was charged to, so repeated
      // flushes keep the total equal to what the memory still owes us.
      drop_cnt    <= inflight - CNT_W'(memRespValid && (inflight != '0));
    end else begin
      if (req_fire) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + DATA_W'(4);
      end
      if (resp_fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PTR_W'(1);
      end
      // Placed after the fill so a bypassed head (fill and pop of the same
      // entry) ends up freed.
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PTR_W'(1);
        last_pc            <= pc_q[head_ptr];
      end
      count       <= count + CNT_W'(req_fire) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_fill);
      drop_cnt    <= drop_cnt - CNT_W'(resp_drop);
    end
  end

`ifndef SYNTHESIS
  // A response the queue never asked for is a memory protocol error.
  resp_has_owner: assert property (@(posedge clk) disable iff (!resetIn)
    memRespValid |-> ((drop_cnt != '0) || (outstanding != '0)));
`endif

endmodule
